// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the NOP used
// for flushed slots and the bundle of per-bank stall/flush controls.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2,
        DRAIN     = 2'd3
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

    // Whole front end frozen, a bubble falls into WB.
    function automatic pipe_ctrl_t ctrl_full_stall();
        pipe_ctrl_t c;
        c              = CTRL_NONE;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_wb_flush = 1'b1;
        return c;
    endfunction

    // Hold PC and ID, inject a bubble into EX.
    function automatic pipe_ctrl_t ctrl_hold_id();
        pipe_ctrl_t c;
        c             = CTRL_NONE;
        c.pc_stall    = 1'b1;
        c.if_id_stall = 1'b1;
        c.id_ex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_CNT_WIDTH = 32
);
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic                      id_uses_rs1;
    logic                      id_uses_rs2;
    logic                      id_serialize;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_is_load;
    logic                      ex_redirect;
    logic [DATA_WIDTH-1:0]     ex_target;
    logic                      imem_ready;
    logic                      mem_req;
    logic                      dmem_ready;

    logic                      pc_stall;
    logic                      pc_redirect;
    logic [DATA_WIDTH-1:0]     pc_target;
    logic                      if_id_stall;
    logic                      if_id_flush;
    logic                      id_ex_stall;
    logic                      id_ex_flush;
    logic                      ex_mem_stall;
    logic                      mem_wb_flush;
    logic [PERF_CNT_WIDTH-1:0] stall_cycles;
    logic [PERF_CNT_WIDTH-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
               ex_rd, ex_is_load, ex_redirect, ex_target,
               imem_ready, mem_req, dmem_ready,
        input  pc_stall, pc_redirect, pc_target, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_serialize,
               ex_rd, ex_is_load, ex_redirect, ex_target,
               imem_ready, mem_req, dmem_ready,
        output pc_stall, pc_redirect, pc_target, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory wait
// states, EX redirects and fence/ecall drain.
//   state     | meaning
//   RUN       | normal issue; load-use and fetch stalls resolved in place
//   DMEM_WAIT | data memory busy, whole pipe frozen; exit cycle acts as RUN
//   REDIRECT  | redirect pending until fetch accepts the latched target
//   DRAIN     | serializing instruction held in ID while EX/MEM/WB empty
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DRAIN_CYCLES   = 3,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    // The detection cycle already drains one slot, so the counter covers the rest.
    localparam logic [CNT_W-1:0]          DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG   = '0;

    ctrl_state_t           r_state;
    logic [CNT_W-1:0]      r_drain_cnt;
    logic [DATA_WIDTH-1:0] r_target;
    logic                  r_serialize_done;

    ctrl_state_t           w_state_nxt;
    logic [CNT_W-1:0]      w_drain_nxt;
    logic [DATA_WIDTH-1:0] w_target_nxt;
    logic                  w_ser_set;
    logic                  w_ser_done_nxt;
    pipe_ctrl_t            w_ctrl;
    logic [DATA_WIDTH-1:0] w_pc_target;
    logic                  w_flush_inc;
    logic                  w_dmem_stall;
    logic                  w_load_use;
    logic                  w_stall_inc;
    logic                  w_flush_cnt_inc;

    assign w_dmem_stall = bus.mem_req & ~bus.dmem_ready;
    assign w_load_use   = bus.ex_is_load & (bus.ex_rd != ZERO_REG) &
                          ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                           (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= RUN;
            r_drain_cnt      <= '0;
            r_target         <= '0;
            r_serialize_done <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_drain_cnt      <= w_drain_nxt;
            r_target         <= w_target_nxt;
            r_serialize_done <= w_ser_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_target_nxt = r_target;
        w_ser_set    = 1'b0;
        w_ctrl       = CTRL_NONE;
        w_pc_target  = '0;
        w_flush_inc  = 1'b0;

        if (r_state == REDIRECT) begin
            w_ctrl.pc_redirect = 1'b1;
            w_ctrl.if_id_flush = 1'b1;
            w_pc_target        = r_target;
            if (bus.imem_ready) begin
                w_state_nxt = RUN;
            end
        end else if (w_dmem_stall) begin
            // EX is frozen here, so any redirect it shows is replayed on exit.
            w_ctrl      = ctrl_full_stall();
            w_state_nxt = DMEM_WAIT;
            w_drain_nxt = '0;
        end else if (bus.ex_redirect) begin
            w_ctrl.pc_redirect = 1'b1;
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            w_pc_target        = bus.ex_target;
            w_flush_inc        = 1'b1;
            w_drain_nxt        = '0;
            if (bus.imem_ready) begin
                w_state_nxt = RUN;
            end else begin
                w_state_nxt  = REDIRECT;
                w_target_nxt = bus.ex_target;
            end
        end else if (r_state == DRAIN) begin
            if (r_drain_cnt != '0) begin
                w_ctrl      = ctrl_hold_id();
                w_drain_nxt = r_drain_cnt - CNT_W'(1);
            end else begin
                w_state_nxt = RUN;
                w_ser_set   = 1'b1;
                if (!bus.imem_ready) begin
                    w_ctrl.pc_stall    = 1'b1;
                    w_ctrl.if_id_flush = 1'b1;
                end
            end
        end else begin
            w_state_nxt = RUN;
            if (bus.id_serialize && !r_serialize_done) begin
                w_ctrl      = ctrl_hold_id();
                w_drain_nxt = DRAIN_LOAD;
                w_state_nxt = DRAIN;
            end else if (w_load_use) begin
                w_ctrl = ctrl_hold_id();
            end else if (!bus.imem_ready) begin
                w_ctrl.pc_stall    = 1'b1;
                w_ctrl.if_id_flush = 1'b1;
            end
        end
    end

    assign w_ser_done_nxt = w_ser_set | (r_serialize_done & w_ctrl.if_id_stall);

    assign bus.pc_stall     = reset & w_ctrl.pc_stall;
    assign bus.pc_redirect  = reset & w_ctrl.pc_redirect;
    assign bus.pc_target    = reset ? w_pc_target : '0;
    assign bus.if_id_stall  = reset & w_ctrl.if_id_stall;
    assign bus.if_id_flush  = reset & w_ctrl.if_id_flush;
    assign bus.id_ex_stall  = reset & w_ctrl.id_ex_stall;
    assign bus.id_ex_flush  = reset & w_ctrl.id_ex_flush;
    assign bus.ex_mem_stall = reset & w_ctrl.ex_mem_stall;
    assign bus.mem_wb_flush = reset & w_ctrl.mem_wb_flush;

    assign w_stall_inc     = reset & w_ctrl.pc_stall;
    assign w_flush_cnt_inc = reset & w_flush_inc;

    hazard_sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .o_count (bus.stall_cycles)
    );

    hazard_sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush_cnt_inc),
        .o_count (bus.flush_events)
    );
endmodule
